// File: rtl/wb_cmd_master.sv
// Purpose : UART byte-command to Wishbone single-cycle master ('W' adr dat / 'R' adr -> 'K' / rd data / 'E').
// Latency : bus cycle starts the cycle after the last command byte; response starts the cycle after ack/timeout.
// Backpress: rx has no backpressure (bytes outside IDLE/ADDR/DATA are dropped); tx holds tx_valid/tx_data until tx_ready.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   rx_data, rx_valid           received byte + single-cycle strobe
//   tx_data, tx_valid, tx_ready  response byte, valid/ready handshake
//   wbm_cyc_o..wbm_sel_o        Wishbone master request (sel is all-ones during a cycle)
//   wbm_ack_i, wbm_dat_i        Wishbone slave acknowledge and read data
//   busy                        high whenever not in IDLE
module wb_cmd_master #(
  parameter int TIMEOUT = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        busy
);

  localparam logic [7:0]  CMD_WR  = 8'h57;
  localparam logic [7:0]  CMD_RD  = 8'h52;
  localparam logic [7:0]  RSP_OK  = 8'h4B;
  localparam logic [7:0]  RSP_ERR = 8'h45;
  // Abort happens on the edge that ends the TIMEOUT-th unacknowledged bus cycle.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

  state_t      state, state_nxt;
  logic        is_wr;
  logic        timed_out;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic [31:0] rd_q;
  logic [1:0]  byte_cnt;
  logic [1:0]  resp_idx;
  logic [15:0] to_cnt;

  logic        rx_last;
  logic        to_expired;
  logic        resp_last;
  logic [7:0]  resp_byte;

  assign rx_last    = rx_valid && (byte_cnt == 2'd3);
  assign to_expired = (to_cnt == TO_LAST);
  // Only a successful read has a multi-byte response.
  assign resp_last  = timed_out || is_wr || (resp_idx == 2'd3);

  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

  always_comb begin
    resp_byte = RSP_OK;
    if (timed_out) begin
      resp_byte = RSP_ERR;
    end else if (!is_wr) begin
      case (resp_idx)
        2'd0:    resp_byte = rd_q[31:24];
        2'd1:    resp_byte = rd_q[23:16];
        2'd2:    resp_byte = rd_q[15:8];
        default: resp_byte = rd_q[7:0];
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_we_o  = 1'b0;
    wbm_sel_o = 4'h0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (rx_valid && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        if (rx_last) begin
          state_nxt = is_wr ? DATA : BUS;
        end
      end
      DATA: begin
        if (rx_last) begin
          state_nxt = BUS;
        end
      end
      BUS: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_we_o  = is_wr;
        wbm_sel_o = 4'hF;
        // Ack takes priority over an expiring timeout.
        if (wbm_ack_i || to_expired) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        tx_valid = 1'b1;
        tx_data  = resp_byte;
        if (tx_ready && resp_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      is_wr     <= 1'b0;
      timed_out <= 1'b0;
      adr_q     <= 32'h0;
      dat_q     <= 32'h0;
      rd_q      <= 32'h0;
      byte_cnt  <= 2'd0;
      resp_idx  <= 2'd0;
      to_cnt    <= 16'd0;
    end else begin
      // Counters are held at zero outside the state that uses them,
      // so each entry into BUS/RESP starts from a clean count.
      if (state != BUS) to_cnt <= 16'd0;
      if (state != RESP) resp_idx <= 2'd0;
      case (state)
        IDLE: begin
          byte_cnt  <= 2'd0;
          timed_out <= 1'b0;
          if (rx_valid && rx_data == CMD_WR) begin
            is_wr <= 1'b1;
          end else if (rx_valid && rx_data == CMD_RD) begin
            is_wr <= 1'b0;
          end
        end
        ADDR: begin
          if (rx_valid) begin
            adr_q    <= {adr_q[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        DATA: begin
          if (rx_valid) begin
            dat_q    <= {dat_q[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        BUS: begin
          if (wbm_ack_i) begin
            rd_q <= wbm_dat_i;
          end else if (to_expired) begin
            timed_out <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        RESP: begin
          if (tx_ready) begin
            resp_idx <= resp_idx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: directed table, hand-written reset/junk sequences,
// then randomized commands against a response model.
module tb_wb_cmd_master;

  localparam int TO = 16;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;
  logic        busy;

  wb_cmd_master #(.TIMEOUT(TO)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_ack_i(wbm_ack_i),
    .wbm_dat_i(wbm_dat_i),
    .busy     (busy)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int cyc_num = 0;
  always @(posedge wb_clk_i) cyc_num <= cyc_num + 1;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    bit          acked;
    int          len;
    bit          unstable;
  } brec_t;

  typedef struct {
    logic        wr;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] rdv;
    int          lat;
    int          stall;
    int          exp_n;
    logic [31:0] exp_tx;
    bit          exp_ack;
    int          exp_len;
  } vec_t;

  brec_t      bus_log[$];
  logic [7:0] tx_q[$];
  int         tx_cyc[$];
  int         tx_unstable;
  int         early_cyc;
  bit         slave_en;
  int         ack_lat;
  logic [31:0] rd_val;
  int         stall_left;
  bit         rand_ready;
  int         n_pass = 0;
  int         n_total = 0;
  vec_t       vecs[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Wishbone slave: acks after ack_lat cycles of cyc (never if negative),
  // and logs each bus cycle when cyc falls.
  task automatic slave_proc();
    brec_t cur;
    bit in_cyc = 0;
    int cnt = 0;
    cur = '{default: 0};
    forever begin
      @(negedge wb_clk_i);
      if (wbm_cyc_o && wbm_stb_o) begin
        if (!in_cyc) begin
          in_cyc = 1; cnt = 0;
          cur = '{we: wbm_we_o, adr: wbm_adr_o, dat: wbm_dat_o, sel: wbm_sel_o,
                  acked: 0, len: 0, unstable: 0};
        end else if (wbm_we_o !== cur.we || wbm_adr_o !== cur.adr ||
                     wbm_dat_o !== cur.dat || wbm_sel_o !== cur.sel) begin
          cur.unstable = 1;
        end
        cur.len++;
        if (slave_en) begin
          if (ack_lat >= 0 && cnt == ack_lat) begin
            wbm_ack_i = 1'b1; wbm_dat_i = rd_val; cur.acked = 1;
          end else begin
            wbm_ack_i = 1'b0; wbm_dat_i = $urandom;
          end
        end
        cnt++;
      end else begin
        if (in_cyc) begin bus_log.push_back(cur); in_cyc = 0; end
        if (slave_en) wbm_ack_i = 1'b0;
      end
    end
  endtask

  // Transmit sink: stalls stall_left cycles, optionally random ready,
  // records accepted bytes and flags data changing while stalled.
  task automatic sink_proc();
    logic [7:0] held = 8'h00;
    bit holding = 0;
    forever begin
      @(negedge wb_clk_i);
      if (tx_valid) begin
        if (holding && tx_data !== held) tx_unstable++;
        if (stall_left > 0) begin
          tx_ready = 1'b0; stall_left--; holding = 1; held = tx_data;
        end else if (rand_ready && $urandom_range(0, 1) == 0) begin
          tx_ready = 1'b0; holding = 1; held = tx_data;
        end else begin
          tx_ready = 1'b1; tx_q.push_back(tx_data); tx_cyc.push_back(cyc_num); holding = 0;
        end
      end else begin
        tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        holding = 0;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge wb_clk_i);
    if (wbm_cyc_o) early_cyc++;
    rx_data = b; rx_valid = 1'b1;
    @(negedge wb_clk_i);
    rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] adr, input logic [31:0] dat);
    send_byte(wr ? 8'h57 : 8'h52);
    for (int i = 0; i < 4; i++) send_byte(adr[31-8*i -: 8]);
    if (wr) for (int i = 0; i < 4; i++) send_byte(dat[31-8*i -: 8]);
  endtask

  // Waits for busy to drop; optionally injects random rx bytes while busy.
  task automatic wait_done(input string tag, input bit junk);
    bit done = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge wb_clk_i);
      if (!busy) done = 1;
      else begin
        rx_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        rx_data  = 8'($urandom);
      end
    end
    rx_valid = 1'b0;
    check({tag, "_idle_in_budget"}, 32'(done), 32'd1);
  endtask

  task automatic pulse_reset();
    @(negedge wb_clk_i); wb_rst_i = 1'b1;
    @(negedge wb_clk_i); wb_rst_i = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic wr, input logic [31:0] adr,
                              input logic [31:0] dat, input int exp_n, input logic [31:0] exp_tx,
                              input bit exp_ack, input int exp_len, input bit consec);
    check({tag, "_ntx"}, 32'(tx_q.size()), 32'(exp_n));
    for (int i = 0; i < exp_n && i < tx_q.size(); i++) begin
      check($sformatf("%s_tx%0d", tag, i), 32'(tx_q[i]), 32'(exp_tx[31-8*i -: 8]));
      if (consec && i > 0) check($sformatf("%s_tx%0d_back2back", tag, i), 32'(tx_cyc[i] - tx_cyc[i-1]), 32'd1);
    end
    check({tag, "_tx_hold"}, 32'(tx_unstable), 32'd0);
    check({tag, "_early_cyc"}, 32'(early_cyc), 32'd0);
    check({tag, "_nbus"}, 32'(bus_log.size()), 32'd1);
    if (bus_log.size() >= 1) begin
      check({tag, "_we"}, 32'(bus_log[0].we), 32'(wr));
      check({tag, "_adr"}, bus_log[0].adr, adr);
      if (wr) check({tag, "_dat"}, bus_log[0].dat, dat);
      check({tag, "_sel"}, 32'(bus_log[0].sel), 32'hF);
      check({tag, "_acked"}, 32'(bus_log[0].acked), 32'(exp_ack));
      check({tag, "_cyc_len"}, 32'(bus_log[0].len), 32'(exp_len));
      check({tag, "_bus_stable"}, 32'(bus_log[0].unstable), 32'd0);
    end
  endtask

  task automatic clear_logs();
    bus_log.delete(); tx_q.delete(); tx_cyc.delete();
    tx_unstable = 0; early_cyc = 0;
  endtask

  // One full command: send, confirm cyc rises right after the last byte, drain.
  task automatic run_cmd(input string tag, input logic wr, input logic [31:0] adr,
                         input logic [31:0] dat, input bit junk);
    send_cmd(wr, adr, dat);
    check({tag, "_cyc_after_last_byte"}, 32'(wbm_cyc_o & wbm_stb_o), 32'd1);
    wait_done(tag, junk);
    @(negedge wb_clk_i);
  endtask

  // Reference: what the host must see for a command, given slave ack latency.
  function automatic void model(input logic wr, input logic [31:0] rdv, input int lat,
                                output int n, output logic [31:0] bytes,
                                output bit acked, output int len);
    acked = (lat >= 0) && (lat < TO);
    len   = acked ? lat + 1 : TO;
    if (!acked)  begin n = 1; bytes = 32'h45000000; end
    else if (wr) begin n = 1; bytes = 32'h4B000000; end
    else         begin n = 4; bytes = rdv; end
  endfunction

  task automatic set_vec(input int i, input logic wr, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [31:0] rdv, input int lat, input int stall, input int n,
                         input logic [31:0] tx, input bit ack, input int len);
    vecs[i] = '{wr: wr, adr: adr, dat: dat, rdv: rdv, lat: lat, stall: stall,
                exp_n: n, exp_tx: tx, exp_ack: ack, exp_len: len};
  endtask

  initial begin
    set_vec(0, 1, 32'h30000004, 32'hDEADBEEF, 32'h0,        3,  0,  1, 32'h4B000000, 1, 4);
    set_vec(1, 0, 32'h30000008, 32'h0,        32'h12345678, 2,  10, 4, 32'h12345678, 1, 3);
    set_vec(2, 0, 32'h00000010, 32'h0,        32'h0,        -1, 0,  1, 32'h45000000, 0, 16);
    set_vec(3, 1, 32'h0000000C, 32'h01020304, 32'h0,        -1, 0,  1, 32'h45000000, 0, 16);
    set_vec(4, 0, 32'hFFFFFFFC, 32'h0,        32'hA5A55A5A, 0,  0,  4, 32'hA5A55A5A, 1, 1);
    set_vec(5, 0, 32'h12345678, 32'h0,        32'hCAFEF00D, 15, 0,  4, 32'hCAFEF00D, 1, 16);
    set_vec(6, 1, 32'h80000000, 32'hFFFFFFFF, 32'h0,        16, 0,  1, 32'h45000000, 0, 16);
    set_vec(7, 1, 32'h00000000, 32'h00000000, 32'h0,        1,  3,  1, 32'h4B000000, 1, 2);

    wb_rst_i = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
    slave_en = 1; ack_lat = 0; rd_val = 0; stall_left = 0; rand_ready = 0;
    tx_unstable = 0; early_cyc = 0;
    fork
      slave_proc();
      sink_proc();
    join_none

    // Reset state, with a command byte strobing during reset.
    repeat (3) begin @(negedge wb_clk_i); rx_valid = 1'b1; rx_data = 8'h57; end
    @(negedge wb_clk_i); rx_valid = 1'b0;
    @(negedge wb_clk_i);
    check("rst_cyc", 32'(wbm_cyc_o), 0);
    check("rst_stb", 32'(wbm_stb_o), 0);
    check("rst_we", 32'(wbm_we_o), 0);
    check("rst_sel", 32'(wbm_sel_o), 0);
    check("rst_adr", wbm_adr_o, 0);
    check("rst_dat", wbm_dat_o, 0);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_busy", 32'(busy), 0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    check("post_rst_busy", 32'(busy), 0);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      clear_logs();
      ack_lat = vecs[i].lat; rd_val = vecs[i].rdv; stall_left = vecs[i].stall;
      run_cmd($sformatf("vec%0d", i), vecs[i].wr, vecs[i].adr, vecs[i].dat, 0);
      check_result($sformatf("vec%0d", i), vecs[i].wr, vecs[i].adr, vecs[i].dat,
                   vecs[i].exp_n, vecs[i].exp_tx, vecs[i].exp_ack, vecs[i].exp_len, 1);
    end

    // Junk bytes in IDLE start nothing; junk during BUS/RESP is ignored.
    clear_logs();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h41);
    repeat (4) @(negedge wb_clk_i);
    check("junk_no_bus", 32'(bus_log.size()), 0);
    check("junk_busy", 32'(busy), 0);
    check("junk_no_tx", 32'(tx_q.size()), 0);
    ack_lat = 5;
    run_cmd("junk_wr", 1, 32'h30000004, 32'hDEADBEEF, 1);
    check_result("junk_wr", 1, 32'h30000004, 32'hDEADBEEF, 1, 32'h4B000000, 1, 6, 1);

    // Reset mid-command: the byte counter must restart cleanly.
    clear_logs();
    send_byte(8'h57); send_byte(8'h30); send_byte(8'h00);
    pulse_reset();
    check("midcmd_rst_busy", 32'(busy), 0);
    ack_lat = 1; rd_val = 32'h0BADF00D;
    run_cmd("midcmd", 0, 32'h00000020, 32'h0, 0);
    check_result("midcmd", 0, 32'h00000020, 32'h0, 4, 32'h0BADF00D, 1, 2, 1);

    // Reset during BUS, then a late ack must be ignored.
    clear_logs();
    slave_en = 0; wbm_ack_i = 1'b0;
    send_cmd(0, 32'h30000008, 32'h0);
    check("busrst_cyc_on", 32'(wbm_cyc_o), 1);
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    check("busrst_cyc", 32'(wbm_cyc_o), 0);
    check("busrst_stb", 32'(wbm_stb_o), 0);
    check("busrst_busy", 32'(busy), 0);
    wb_rst_i = 1'b0; wbm_ack_i = 1'b1; wbm_dat_i = 32'h11223344;
    @(negedge wb_clk_i); wbm_ack_i = 1'b0;
    begin
      int bad = 0;
      repeat (6) begin @(negedge wb_clk_i); if (busy || tx_valid || wbm_cyc_o) bad++; end
      check("busrst_late_ack_quiet", 32'(bad), 0);
    end
    check("busrst_no_tx", 32'(tx_q.size()), 0);
    slave_en = 1;
    clear_logs();
    ack_lat = 3;
    run_cmd("busrst_next", 1, 32'h30000004, 32'hDEADBEEF, 0);
    check_result("busrst_next", 1, 32'h30000004, 32'hDEADBEEF, 1, 32'h4B000000, 1, 4, 1);

    // Randomized commands against the model.
    rand_ready = 1;
    for (int it = 0; it < 40; it++) begin
      logic wr; logic [31:0] adr, dat, rdv, ebytes; int lat, en, elen; bit eack;
      clear_logs();
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        logic [7:0] b;
        b = 8'($urandom);
        if (b == 8'h57 || b == 8'h52) b = b ^ 8'h01;
        send_byte(b);
      end
      wr = 1'($urandom_range(0, 1)); adr = $urandom; dat = $urandom; rdv = $urandom;
      lat = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 20));
      ack_lat = lat; rd_val = rdv;
      model(wr, rdv, lat, en, ebytes, eack, elen);
      run_cmd($sformatf("rnd%0d", it), wr, adr, dat, 1);
      check_result($sformatf("rnd%0d", it), wr, adr, dat, en, ebytes, eack, elen, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
